// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Brief    : Multi-cycle issue controller that feeds the combinational ALU
//            and returns a write-back/branch response per instruction.
// Options  : ALU_ISSUE_OVF_EN enables signed-overflow detection on add/sub/addi.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctr,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_reg,
    output logic        wb_en,
    output logic        branch_taken,
    output logic        illegal,
    output logic        ovf
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DECODE = 2'd1;
    localparam logic [1:0] c_EXEC   = 2'd2;
    localparam logic [1:0] c_RESP   = 2'd3;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b100;
    localparam logic [2:0] c_ALU_AND = 3'b001;
    localparam logic [2:0] c_ALU_OR  = 3'b010;
    localparam logic [2:0] c_ALU_XOR = 3'b101;
    localparam logic [2:0] c_ALU_LUI = 3'b110;

    logic [1:0]  r_state;
    logic [5:0]  r_op;
    logic [4:0]  r_rt_idx;
    logic [15:0] r_imm;
    logic [31:0] r_rs;
    logic [31:0] r_rt;
    logic        r_is_branch;
    logic        r_is_bne;
    logic        r_wr;

    logic [31:0] r_alu_a;
    logic [31:0] r_alu_b;
    logic [2:0]  r_alu_ctr;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_reg;
    logic        r_wb_en;
    logic        r_branch_taken;
    logic        r_illegal;

    logic [5:0]  w_funct;
    logic [4:0]  w_rd;
    logic        w_legal;
    logic [2:0]  w_ctr;
    logic [31:0] w_b;
    logic [4:0]  w_dest;
    logic        w_branch;
    logic        w_bne;
    logic        w_ovf;

    // rs/rt register indices arrive already resolved as rs_data/rt_data
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, instr[25:21]};

    // rd and funct both live inside the latched immediate field
    assign w_funct = r_imm[5:0];
    assign w_rd    = r_imm[15:11];

    always_comb begin
        w_legal  = 1'b1;
        w_ctr    = c_ALU_ADD;
        w_b      = r_rt;
        w_dest   = r_rt_idx;
        w_branch = 1'b0;
        w_bne    = 1'b0;
        case (r_op)
            6'b000000: begin
                w_dest = w_rd;
                case (w_funct)
                    6'b100000, 6'b100001: w_ctr = c_ALU_ADD;
                    6'b100010, 6'b100011: w_ctr = c_ALU_SUB;
                    6'b100100:            w_ctr = c_ALU_AND;
                    6'b100101:            w_ctr = c_ALU_OR;
                    6'b100110:            w_ctr = c_ALU_XOR;
                    default:              w_legal = 1'b0;
                endcase
            end
            6'b001000, 6'b001001: begin
                w_ctr = c_ALU_ADD;
                w_b   = {{16{r_imm[15]}}, r_imm};
            end
            6'b001100: begin
                w_ctr = c_ALU_AND;
                w_b   = {16'h0, r_imm};
            end
            6'b001101: begin
                w_ctr = c_ALU_OR;
                w_b   = {16'h0, r_imm};
            end
            6'b001110: begin
                w_ctr = c_ALU_XOR;
                w_b   = {16'h0, r_imm};
            end
            6'b001111: begin
                w_ctr = c_ALU_LUI;
                w_b   = {16'h0, r_imm};
            end
            6'b000100, 6'b000101: begin
                // Branches never write back; destination reported as $0
                w_ctr    = c_ALU_SUB;
                w_dest   = 5'd0;
                w_branch = 1'b1;
                w_bne    = r_op[0];
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            w_ctr  = c_ALU_ADD;
            w_dest = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_IDLE;
            r_op           <= '0;
            r_rt_idx       <= '0;
            r_imm          <= '0;
            r_rs           <= '0;
            r_rt           <= '0;
            r_is_branch    <= 1'b0;
            r_is_bne       <= 1'b0;
            r_wr           <= 1'b0;
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_ctr      <= '0;
            r_wb_data      <= '0;
            r_wb_reg       <= '0;
            r_wb_en        <= 1'b0;
            r_branch_taken <= 1'b0;
            r_illegal      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_op     <= instr[31:26];
                        r_rt_idx <= instr[20:16];
                        r_imm    <= instr[15:0];
                        r_rs     <= rs_data;
                        r_rt     <= rt_data;
                        r_state  <= c_DECODE;
                    end
                end
                c_DECODE: begin
                    r_alu_a        <= r_rs;
                    r_alu_b        <= w_b;
                    r_alu_ctr      <= w_ctr;
                    r_wb_reg       <= w_dest;
                    r_illegal      <= ~w_legal;
                    r_wb_en        <= 1'b0;
                    r_branch_taken <= 1'b0;
                    r_is_branch    <= w_branch;
                    r_is_bne       <= w_bne;
                    r_wr           <= w_legal && !w_branch && (w_dest != 5'd0);
                    if (w_legal) begin
                        r_state <= c_EXEC;
                    end else begin
                        r_wb_data <= '0;
                        r_state   <= c_RESP;
                    end
                end
                c_EXEC: begin
                    r_wb_data      <= alu_result;
                    r_branch_taken <= r_is_branch & (alu_zero ^ r_is_bne);
                    r_wb_en        <= r_wr & ~w_ovf;
                    r_state        <= c_RESP;
                end
                c_RESP: begin
                    if (out_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_OVF_EN
    logic w_ovf_chk_d;
    logic w_ovf_sub_d;
    logic r_ovf_chk;
    logic r_ovf_sub;
    logic r_ovf;

    // Only the trapping forms (add, sub, addi) are checked
    assign w_ovf_chk_d = w_legal &&
                         (((r_op == 6'b000000) &&
                           ((w_funct == 6'b100000) || (w_funct == 6'b100010))) ||
                          (r_op == 6'b001000));
    assign w_ovf_sub_d = (r_op == 6'b000000) && (w_funct == 6'b100010);

    assign w_ovf = r_ovf_chk &
                   (r_ovf_sub ? ((r_alu_a[31] != r_alu_b[31]) && (alu_result[31] != r_alu_a[31]))
                              : ((r_alu_a[31] == r_alu_b[31]) && (alu_result[31] != r_alu_a[31])));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf_chk <= 1'b0;
            r_ovf_sub <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (r_state == c_DECODE) begin
            r_ovf_chk <= w_ovf_chk_d;
            r_ovf_sub <= w_ovf_sub_d;
            r_ovf     <= 1'b0;
        end else if (r_state == c_EXEC) begin
            r_ovf     <= w_ovf;
        end
    end

    assign ovf = r_ovf;
`else
    assign w_ovf = 1'b0;
    assign ovf   = 1'b0;
`endif

    assign in_ready     = (r_state == c_IDLE);
    assign out_valid    = (r_state == c_RESP);
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_ctr      = r_alu_ctr;
    assign wb_data      = r_wb_data;
    assign wb_reg       = r_wb_reg;
    assign wb_en        = r_wb_en;
    assign branch_taken = r_branch_taken;
    assign illegal      = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue_ctrl
// Brief    : Scoreboard bench for alu_issue_ctrl with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctr;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_reg;
    logic        wb_en;
    logic        branch_taken;
    logic        illegal;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [43:0] resp;
        logic [31:0] a;
        logic [31:0] b;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb[$];

    logic [43:0] dut_resp;
    assign dut_resp = {illegal, wb_en, branch_taken, ovf, alu_ctr, wb_reg, wb_data};

    alu_issue_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_ctr      (alu_ctr),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .wb_data      (wb_data),
        .wb_reg       (wb_reg),
        .wb_en        (wb_en),
        .branch_taken (branch_taken),
        .illegal      (illegal),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    // Combinational ALU sitting on the other side of the interface
    always_comb begin
        case (alu_ctr)
            3'b000:  alu_result = alu_a + alu_b;
            3'b100:  alu_result = alu_a - alu_b;
            3'b001:  alu_result = alu_a & alu_b;
            3'b010:  alu_result = alu_a | alu_b;
            3'b101:  alu_result = alu_a ^ alu_b;
            3'b110:  alu_result = {alu_b[15:0], 16'h0};
            default: alu_result = 32'h0;
        endcase
        alu_zero = (alu_result == 32'h0);
    end

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [5:0]  op;
        logic [5:0]  f;
        logic [15:0] imm;
        logic [31:0] bb;
        logic [31:0] r;
        logic [2:0]  c;
        logic [4:0]  d;
        logic        ill;
        logic        br;
        logic        tk;
        logic        ov;
        logic        chk;
        logic        issub;
        logic        we;
        op = ins[31:26]; f = ins[5:0]; imm = ins[15:0];
        ill = 1'b0; br = 1'b0; tk = 1'b0; ov = 1'b0; chk = 1'b0; issub = 1'b0;
        c = 3'b000; bb = b; d = ins[20:16];
        case (op)
            6'd0: begin
                d = ins[15:11];
                case (f)
                    6'd32: begin c = 3'b000; chk = 1'b1; end
                    6'd33: c = 3'b000;
                    6'd34: begin c = 3'b100; chk = 1'b1; issub = 1'b1; end
                    6'd35: c = 3'b100;
                    6'd36: c = 3'b001;
                    6'd37: c = 3'b010;
                    6'd38: c = 3'b101;
                    default: ill = 1'b1;
                endcase
            end
            6'd8:  begin c = 3'b000; bb = {{16{imm[15]}}, imm}; chk = 1'b1; end
            6'd9:  begin c = 3'b000; bb = {{16{imm[15]}}, imm}; end
            6'd12: begin c = 3'b001; bb = {16'h0, imm}; end
            6'd13: begin c = 3'b010; bb = {16'h0, imm}; end
            6'd14: begin c = 3'b101; bb = {16'h0, imm}; end
            6'd15: begin c = 3'b110; bb = {16'h0, imm}; end
            6'd4:  begin c = 3'b100; br = 1'b1; tk = (a == b); d = 5'd0; end
            6'd5:  begin c = 3'b100; br = 1'b1; tk = (a != b); d = 5'd0; end
            default: ill = 1'b1;
        endcase
        case (c)
            3'b000:  r = a + bb;
            3'b100:  r = a - bb;
            3'b001:  r = a & bb;
            3'b010:  r = a | bb;
            3'b101:  r = a ^ bb;
            default: r = {imm, 16'h0};
        endcase
`ifdef ALU_ISSUE_OVF_EN
        if (chk) begin
            if (issub) ov = (a[31] != bb[31]) && (r[31] != a[31]);
            else       ov = (a[31] == bb[31]) && (r[31] != a[31]);
        end
`else
        ov = 1'b0 & chk & issub;
`endif
        if (ill) begin
            r = 32'h0; c = 3'b000; d = 5'd0;
        end
        we = !ill && !br && (d != 5'd0) && !ov;
        e.resp = {ill, we, tk, ov, c, d, r};
        e.a    = a;
        e.b    = bb;
        e.ill  = ill;
        e.lat  = ill ? 1 : 2;
        return e;
    endfunction

    function automatic logic [31:0] r_type(input int rs, input int rt, input int rd, input logic [5:0] fn);
        r_type = {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        i_type = {op, rs[4:0], rt[4:0], imm};
    endfunction

    // Issue one instruction, then pop its expectation when the response appears
    task automatic run_one(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b, input int stall);
        exp_t        e;
        logic [43:0] snap;
        int          lat;
        int          guard;
        sb.push_back(model(ins, a, b));
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL in_ready_wait: got %b expected 1", in_ready);
        end
        in_valid = 1'b1; instr = ins; rs_data = a; rt_data = b;
        out_ready = (stall == 0);
        @(negedge clk);
        // Garbage with in_valid high must be ignored while busy
        instr = $urandom; rs_data = $urandom; rt_data = $urandom;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if (lat !== e.lat) begin
            n_fail++;
            $display("FAIL latency instr=%h: got %0d expected %0d", ins, lat, e.lat);
        end
        n_checks++;
        if (dut_resp !== e.resp) begin
            n_fail++;
            $display("FAIL response instr=%h: got %h expected %h", ins, dut_resp, e.resp);
        end
        if (!e.ill) begin
            n_checks++;
            if ({alu_a, alu_b} !== {e.a, e.b}) begin
                n_fail++;
                $display("FAIL operands instr=%h: got %h/%h expected %h/%h", ins, alu_a, alu_b, e.a, e.b);
            end
        end
        snap = e.resp;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid, in_ready, dut_resp} !== {1'b1, 1'b0, snap}) begin
                n_fail++;
                $display("FAIL stall_hold cyc=%0d: got v=%b r=%b %h expected v=1 r=0 %h",
                         i, out_valid, in_ready, dut_resp, snap);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL release: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; rs_data = '0; rt_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, dut_resp, alu_a, alu_b} !== {1'b1, 1'b0, 44'h0, 64'h0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b v=%b resp=%h a=%h b=%h expected 1/0/0/0/0",
                     in_ready, out_valid, dut_resp, alu_a, alu_b);
        end
    endtask

    task automatic test_directed();
        run_one(r_type(1, 2, 3, 6'd32), 32'd5, 32'd7, 0);
        run_one(i_type(6'd15, 0, 4, 16'h1234), 32'h0, 32'h0, 0);
        run_one(i_type(6'd8, 0, 5, 16'hFFFF), 32'h0, 32'h0, 0);
        run_one(r_type(6, 7, 8, 6'd34), 32'd3, 32'd10, 0);
        run_one(r_type(6, 7, 9, 6'd36), 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
        run_one(r_type(6, 7, 10, 6'd37), 32'hA000_0001, 32'h0500_0010, 0);
        run_one(r_type(6, 7, 11, 6'd38), 32'hFFFF_0000, 32'h0F0F_0F0F, 0);
        run_one(i_type(6'd14, 2, 12, 16'h8001), 32'hFFFF_FFFF, 32'h0, 0);
    endtask

    task automatic test_branch();
        run_one(i_type(6'd4, 1, 2, 16'd3), 32'd9, 32'd9, 0);
        run_one(i_type(6'd5, 1, 2, 16'd3), 32'd9, 32'd9, 0);
        run_one(i_type(6'd5, 1, 2, 16'd3), 32'd9, 32'd4, 0);
    endtask

    task automatic test_illegal();
        run_one({6'b111111, 26'h155_5555}, 32'd1, 32'd2, 0);
        run_one(r_type(1, 2, 3, 6'b101010), 32'd1, 32'd2, 0);
        run_one(i_type(6'd13, 1, 0, 16'd1), 32'd6, 32'd0, 0);
        run_one(r_type(1, 2, 0, 6'd33), 32'd6, 32'd1, 0);
    endtask

    task automatic test_stall();
        run_one(r_type(4, 5, 6, 6'd33), 32'h1111_1111, 32'h2222_2222, 5);
        run_one({6'b010011, 26'h0}, 32'd1, 32'd2, 3);
    endtask

    task automatic test_reset_in_exec();
        int seen;
        while (in_ready !== 1'b1) @(negedge clk);
        in_valid = 1'b1; instr = r_type(1, 2, 3, 6'd32); rs_data = 32'd1; rt_data = 32'd2;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_exec: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL reset_exec_no_resp: got %0d response cycles expected 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  ops [15];
        logic [5:0]  fns [7];
        logic [31:0] a;
        logic [31:0] b;
        int          k;
        ops = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd8, 6'd9, 6'd12, 6'd13, 6'd14, 6'd15, 6'd4, 6'd5};
        fns = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38};
        for (int n = 0; n < 30; n++) begin
            k = $urandom_range(0, 14);
            a = $urandom;
            b = ($urandom_range(0, 2) == 0) ? a : $urandom;
            if (k < 7)
                run_one(r_type($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), fns[k]), a, b, 0);
            else
                run_one(i_type(ops[k], $urandom_range(0, 31), $urandom_range(0, 31), 16'($urandom)), a, b, 0);
        end
    endtask

`ifdef ALU_ISSUE_OVF_EN
    task automatic test_ovf();
        run_one(r_type(1, 2, 3, 6'd32), 32'h7FFF_FFFF, 32'd1, 0);
        run_one(r_type(1, 2, 3, 6'd33), 32'h7FFF_FFFF, 32'd1, 0);
        run_one(r_type(1, 2, 3, 6'd34), 32'h8000_0000, 32'd1, 0);
        run_one(i_type(6'd8, 1, 3, 16'h0001), 32'h7FFF_FFFF, 32'd0, 0);
    endtask
`else
    task automatic test_ovf();
        run_one(r_type(1, 2, 3, 6'd32), 32'h7FFF_FFFF, 32'd1, 0);
        run_one(r_type(1, 2, 3, 6'd34), 32'h8000_0000, 32'd1, 0);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_branch();
        test_illegal();
        test_stall();
        test_reset_in_exec();
        test_ovf();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
